// File: rtl/dma_bus_sched.sv
// dma_bus_sched -- main-bus scheduler for the GBC core.
//
// Shares the single external/WRAM/ROM read port between the CPU, the
// HDMA/GDMA engine and the FF46 OAM DMA engine. Each granted DMA read is
// turned into a write on the VRAM or OAM port one clock later, when the
// memory returns its data. Grant priority: HDMA > OAM DMA > CPU.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   cpu_addr/rd/wr/wdata    CPU bus request
//   cpu_rdata               data returned to CPU (FF for blocked reads)
//   cpu_stall               CPU freeze while HDMA owns the bus
//   hdma_req/src/dst        one-byte-per-clock HDMA read requests
//   oam_start/oam_page      FF46 write pulse and source page
//   oam_busy                OAM DMA in progress
//   mem_addr/rd/wr/wdata    main bus request
//   mem_rdata               main bus data, valid 1 clk after mem_rd
//   vram_addr/wr/wdata      VRAM write port for HDMA bytes
//   oam_addr/wr/wdata       OAM write port for OAM DMA bytes
module dma_bus_sched #(
    parameter int OAM_LEN  = 160,
    parameter int OAM_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    input  logic        hdma_req,
    input  logic [15:0] hdma_src,
    input  logic [15:0] hdma_dst,
    input  logic        oam_start,
    input  logic [7:0]  oam_page,
    output logic        oam_busy,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [12:0] vram_addr,
    output logic        vram_wr,
    output logic [7:0]  vram_wdata,
    output logic [7:0]  oam_addr,
    output logic        oam_wr,
    output logic [7:0]  oam_wdata
);

    localparam int CW = (OAM_STEP > 2) ? $clog2(OAM_STEP) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(OAM_STEP - 1);
    // The step counter spans the whole byte slot: WAIT leaves two counts
    // early so that WAIT + READ + WRITE together take exactly OAM_STEP clks.
    localparam logic [CW-1:0] CNT_EXIT = CW'(2);
    localparam logic [7:0]    IDX_LAST = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_WRITE} oam_state_e;

    oam_state_e    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    page_q, page_d;

    logic          hdma_vld_q;
    logic [12:0]   hdma_dst_q;
    logic          rd_fwd_q;
    logic [7:0]    rdata_hold_q, rdata_hold_d;

    logic [7:0]    page_remap;
    logic          hram_hit, cpu_pass, cpu_block_rd;
    logic          unused_dst_hi;

    assign unused_dst_hi = ^hdma_dst[15:13];

    // E0-FF is the echo of C0-DF.
    assign page_remap = (oam_page >= 8'hE0) ? (oam_page - 8'h20) : oam_page;

    assign oam_busy  = (state_q != S_IDLE);
    assign cpu_stall = !reset && (hdma_req || hdma_vld_q);
    assign hram_hit  = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);

    // CPU reaches the bus only when not stalled and OAM is not reading;
    // during OAM DMA only HRAM accesses go through.
    assign cpu_pass     = !reset && !cpu_stall && (state_q != S_READ) &&
                          (!oam_busy || hram_hit);
    assign cpu_block_rd = !reset && !cpu_stall && oam_busy && cpu_rd && !cpu_pass;

    // ---------------- OAM FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            page_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            page_q  <= page_d;
        end
    end

    // ---------------- OAM FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        page_d  = page_q;
        if (oam_start) begin
            // A new FF46 write restarts from byte 0 in any state.
            state_d = S_WAIT;
            idx_d   = '0;
            cnt_d   = CNT_LOAD;
            page_d  = page_remap;
        end else begin
            case (state_q)
                S_WAIT: begin
                    // Counter is frozen while HDMA holds the bus.
                    if (!hdma_req) begin
                        if (cnt_q == CNT_EXIT) state_d = S_READ;
                        else                   cnt_d   = cnt_q - 1'b1;
                    end
                end
                S_READ: begin
                    if (!hdma_req) state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- OAM FSM: outputs + bus mux ----------------
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        oam_wr    = 1'b0;
        oam_wdata = '0;
        if (!reset) begin
            if (hdma_req) begin
                mem_addr = hdma_src;
                mem_rd   = 1'b1;
            end else if (state_q == S_READ) begin
                mem_addr = {page_q, idx_q};
                mem_rd   = 1'b1;
            end else if (cpu_pass) begin
                mem_addr  = cpu_addr;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_wdata = cpu_wdata;
            end
            // A restart on the same clock cancels the in-flight byte.
            if (state_q == S_WRITE && !oam_start) begin
                oam_wr    = 1'b1;
                oam_wdata = mem_rdata;
            end
        end
    end

    assign oam_addr = idx_q;

    // ---------------- HDMA write pipeline ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hdma_vld_q <= 1'b0;
            hdma_dst_q <= '0;
        end else begin
            hdma_vld_q <= hdma_req;
            if (hdma_req) hdma_dst_q <= hdma_dst[12:0];
        end
    end

    assign vram_wr    = !reset && hdma_vld_q;
    assign vram_addr  = hdma_dst_q;
    assign vram_wdata = vram_wr ? mem_rdata : 8'h00;

    // ---------------- CPU read return ----------------
    // Forwarded reads see mem_rdata on the clock it arrives; the hold
    // register keeps the last value (or FF after a blocked read).
    always_comb begin
        rdata_hold_d = rdata_hold_q;
        if (cpu_block_rd)  rdata_hold_d = 8'hFF;
        else if (rd_fwd_q) rdata_hold_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_fwd_q     <= 1'b0;
            rdata_hold_q <= 8'hFF;
        end else begin
            rd_fwd_q     <= cpu_pass && cpu_rd;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign cpu_rdata = rd_fwd_q ? mem_rdata : rdata_hold_q;

endmodule

// File: tb/tb_dma_bus_sched.sv
// Self-checking bench for dma_bus_sched. A small memory model returns
// f(addr) one clk after each mem_rd; expected VRAM/OAM writes are queued
// when stimulus is driven and popped when the DUT writes.
module tb_dma_bus_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        hdma_req;
    logic [15:0] hdma_src, hdma_dst;
    logic        oam_start;
    logic [7:0]  oam_page;
    logic        oam_busy;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [12:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic [7:0]  oam_addr;
    logic        oam_wr;
    logic [7:0]  oam_wdata;

    dma_bus_sched #(.OAM_LEN(160), .OAM_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .hdma_req(hdma_req), .hdma_src(hdma_src), .hdma_dst(hdma_dst),
        .oam_start(oam_start), .oam_page(oam_page), .oam_busy(oam_busy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_wdata(vram_wdata),
        .oam_addr(oam_addr), .oam_wr(oam_wr), .oam_wdata(oam_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [12:0] addr; logic [7:0] data;} vram_exp_t;
    typedef struct packed {logic [7:0] idx; logic [7:0] data;} oam_exp_t;

    vram_exp_t vq[$];
    oam_exp_t  oq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int last_oam_cyc = 0;
    bit gap_chk = 1'b1;

    function automatic logic [7:0] f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_oam(input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = {page, 8'(i)};
            oq.push_back('{idx: 8'(i), data: f(a)});
        end
    endtask

    task automatic drain_oam(input string tag);
        int g;
        g = 0;
        while (oq.size() != 0 && g < 2000) begin
            step();
            g++;
        end
        chk(tag, 32'(oq.size()), 32'd0);
    endtask

    // Memory model: data valid exactly one clk after mem_rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem_rd ? f(mem_addr) : 8'h00;
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (cpu_stall) stall_cnt++;
        if (vram_wr) begin
            if (vq.size() == 0) chk("vram_unexp", 32'd1, 32'd0);
            else begin
                vram_exp_t ve;
                ve = vq.pop_front();
                chk("vram_addr", 32'(vram_addr), 32'(ve.addr));
                chk("vram_data", 32'(vram_wdata), 32'(ve.data));
            end
        end
        if (oam_wr) begin
            chk("oam_busy_wr", 32'(oam_busy), 32'd1);
            if (oq.size() == 0) chk("oam_unexp", 32'd1, 32'd0);
            else begin
                oam_exp_t oe;
                oe = oq.pop_front();
                chk("oam_idx", 32'(oam_addr), 32'(oe.idx));
                chk("oam_data", 32'(oam_wdata), 32'(oe.data));
                if (gap_chk && oe.idx != 8'd0)
                    chk("oam_gap", 32'(cyc - last_oam_cyc), 32'd4);
            end
            last_oam_cyc = cyc;
        end
    end

    initial begin
        int t0, t1, s0;
        reset = 1'b1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
        hdma_req = 0; hdma_src = '0; hdma_dst = '0; oam_start = 0; oam_page = '0;
        step(); step(); step();
        #2;
        chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
        chk("rst_busy", 32'(oam_busy), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_memrd", 32'(mem_rd), 32'd0);
        chk("rst_oamaddr", 32'(oam_addr), 32'd0);
        chk("rst_vramaddr", 32'(vram_addr), 32'd0);

        // 1: plain CPU read
        step(); reset = 0; cpu_addr = 16'hC123; cpu_rd = 1; #2;
        chk("cpu_memrd", 32'(mem_rd), 32'd1);
        chk("cpu_memaddr", 32'(mem_addr), 32'hC123);
        chk("cpu_nostall", 32'(cpu_stall), 32'd0);
        step(); cpu_rd = 0; #2;
        chk("cpu_rdata", 32'(cpu_rdata), 32'h5A);
        step(); #2;
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'h5A);

        // 2: HDMA burst of 16, CPU read attempt ignored
        s0 = stall_cnt;
        for (int i = 0; i < 16; i++) begin
            step();
            hdma_req = 1; hdma_src = 16'h2040 + 16'(i); hdma_dst = 16'h8200 + 16'(i);
            cpu_rd = 1; cpu_addr = 16'hC000;
            vq.push_back('{addr: hdma_dst[12:0], data: f(hdma_src)});
            #2;
            chk("hdma_memaddr", 32'(mem_addr), 32'(hdma_src));
            chk("hdma_stall", 32'(cpu_stall), 32'd1);
        end
        step(); hdma_req = 0; cpu_rd = 0; #2;
        chk("hdma_tail_stall", 32'(cpu_stall), 32'd1);
        chk("hdma_cpu_ignored", 32'(cpu_rdata), 32'h5A);
        step(); #2;
        chk("hdma_stall_off", 32'(cpu_stall), 32'd0);
        chk("hdma_stall_len", 32'(stall_cnt - s0), 32'd17);
        chk("hdma_drain", 32'(vq.size()), 32'd0);

        // 3: OAM DMA page C1
        step(); oam_start = 1; oam_page = 8'hC1; t0 = cyc; push_oam(8'hC1, 160);
        step(); oam_start = 0; #2;
        chk("oam_busy_on", 32'(oam_busy), 32'd1);
        drain_oam("oam_c1_drain");
        #2;
        chk("oam_busy_off", 32'(oam_busy), 32'd0);
        chk("oam_total", 32'(last_oam_cyc - t0), 32'd640);

        // 4: echo page F3 -> D3
        step(); oam_start = 1; oam_page = 8'hF3; push_oam(8'hD3, 160);
        step(); oam_start = 0;
        drain_oam("oam_f3_drain");

        // 5: CPU during OAM DMA
        step(); oam_start = 1; oam_page = 8'hC2; push_oam(8'hC2, 160);
        step(); oam_start = 0; cpu_rd = 1; cpu_addr = 16'hC000; #2;
        chk("blk_rd_nomem", 32'(mem_rd), 32'd0);
        step(); cpu_addr = 16'hFF90; #2;
        chk("blk_rdata_ff", 32'(cpu_rdata), 32'hFF);
        chk("hram_memrd", 32'(mem_rd), 32'd1);
        chk("hram_memaddr", 32'(mem_addr), 32'hFF90);
        step(); cpu_rd = 0; #2;
        chk("oam_rd_addr", 32'(mem_addr), 32'hC200);
        chk("hram_rdata", 32'(cpu_rdata), 32'(f(16'hFF90)));
        step(); cpu_wr = 1; cpu_addr = 16'hC000; cpu_wdata = 8'h77; #2;
        chk("blk_wr_nomem", 32'(mem_wr), 32'd0);
        step(); cpu_addr = 16'hFF90; #2;
        chk("hram_memwr", 32'(mem_wr), 32'd1);
        chk("hram_wdata", 32'(mem_wdata), 32'h77);
        step(); cpu_wr = 0;
        drain_oam("oam_c2_drain");

        // 6: HDMA collides with OAM at idx 10, then restart at idx 50
        gap_chk = 0;
        step(); oam_start = 1; oam_page = 8'hC3; t0 = cyc; push_oam(8'hC3, 50);
        t1 = 0;
        for (int c = 1; c <= 213; c++) begin
            step();
            oam_start = 0;
            hdma_req = (c >= 43 && c <= 50);
            if (hdma_req) begin
                hdma_src = 16'h3000 + 16'(c); hdma_dst = 16'h8000 + 16'(c);
                vq.push_back('{addr: hdma_dst[12:0], data: f(hdma_src)});
            end
            if (c == 43) begin #2; chk("col_hdma_wins", 32'(mem_addr), 32'h3000 + 32'(c)); end
            if (c == 51) begin #2; chk("col_resume_addr", 32'(mem_addr), 32'hC30A);
                                   chk("col_resume_rd", 32'(mem_rd), 32'd1); end
            if (c == 53) begin chk("col_idx10_cyc", 32'(last_oam_cyc - t0), 32'd52);
                               chk("col_q_left", 32'(oq.size()), 32'd39); end
            if (c == 212) begin
                chk("restart_q_empty", 32'(oq.size()), 32'd0);
                oam_start = 1; oam_page = 8'hC4; t1 = cyc; push_oam(8'hC4, 160);
                gap_chk = 1;
            end
        end
        drain_oam("restart_drain");
        chk("restart_total", 32'(last_oam_cyc - t1), 32'd640);
        chk("col_vram_drain", 32'(vq.size()), 32'd0);

        // 7: reset mid-transfer with an HDMA write pending
        step(); oam_start = 1; oam_page = 8'hC5; t0 = cyc; push_oam(8'hC5, 5);
        for (int c = 1; c <= 19; c++) begin step(); oam_start = 0; end
        step(); hdma_req = 1; hdma_src = 16'h2155; hdma_dst = 16'h8155;
        step(); hdma_req = 0; reset = 1;
        step(); reset = 0; #2;
        chk("mid_rst_busy", 32'(oam_busy), 32'd0);
        chk("mid_rst_vaddr", 32'(vram_addr), 32'd0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'hFF);
        chk("mid_rst_oamaddr", 32'(oam_addr), 32'd0);
        for (int c = 0; c < 10; c++) step();
        chk("mid_rst_oq", 32'(oq.size()), 32'd0);
        chk("final_vq", 32'(vq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
